// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader:
// FSM state encoding, stream framing constants and a state classifier.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN0  = 3'd0,
    ST_LEN1  = 3'd1,
    ST_DATA  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  // States in which the loader takes bytes from the stream.
  function automatic logic accepting(state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_pack.sv
// Byte-to-word assembler: collects little-endian bytes into a 32-bit word.
// word_ready is a combinational strobe on the byte that completes a word;
// word is valid in that same cycle (first byte lands in word[7:0]).
import imem_loader_pkg::*;

module imem_loader_pack (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [7:0]        in_data,
  output logic              word_ready,
  output logic [WORD_W-1:0] word
);

  logic [BYTE_CNT_W-1:0] cnt_reg;
  logic [WORD_W-9:0]     shift_reg;

  // Byte counter and right-shifting holding register for the first three bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      shift_reg <= '0;
    end else if (en) begin
      cnt_reg   <= cnt_reg + 1'b1;
      shift_reg <= {in_data, shift_reg[WORD_W-9:8]};
    end
  end

  assign word_ready = en && (cnt_reg == BYTE_CNT_W'(BYTES_PER_WORD - 1));
  assign word       = {in_data, shift_reg};

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer. Parses a 16-bit word count header,
// writes the following little-endian words to addresses 0..count-1 and
// releases core_hold once the image is complete.
// Optional feature macro: IMEM_LOADER_CSUM_EN (trailing XOR checksum byte).
import imem_loader_pkg::*;

module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  localparam int HDR_W    = HDR_BYTES * 8;
  localparam int CAPACITY = 1 << ADDR_W;

`ifdef IMEM_LOADER_CSUM_EN
  localparam state_t AFTER_DATA = ST_CSUM;
`else
  localparam state_t AFTER_DATA = ST_FLUSH;
`endif

  state_t              state_reg, state_next;
  logic                in_ready_reg, in_ready_next;
  logic [7:0]          count_lo_reg;
  logic [HDR_W-1:0]    count_reg;
  logic [HDR_W:0]      words_reg;
  logic                mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [WORD_W-1:0]   mem_wdata_reg;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]          csum_reg;
`endif

  logic                xfer;
  logic                pack_en;
  logic                word_ready;
  logic [WORD_W-1:0]   word;
  logic [HDR_W-1:0]    hdr_word;
  logic                last_word;
  logic                too_big;

  assign xfer      = in_valid && in_ready_reg;
  assign pack_en   = xfer && (state_reg == ST_DATA);
  assign hdr_word  = {in_data, count_lo_reg};
  assign too_big   = {1'b0, hdr_word} > (HDR_W + 1)'(CAPACITY);
  assign last_word = (words_reg + 1'b1) == {1'b0, count_reg};

  imem_loader_pack u_pack (
    .clk        (clk),
    .rst        (rst),
    .en         (pack_en),
    .in_data    (in_data),
    .word_ready (word_ready),
    .word       (word)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_LEN0;
    else     state_reg <= state_next;
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LEN0:  if (xfer) state_next = ST_LEN1;
      ST_LEN1: begin
        if (xfer) begin
          if (hdr_word == '0)  state_next = AFTER_DATA;
          else if (too_big)    state_next = ST_ERR;
          else                 state_next = ST_DATA;
        end
      end
      ST_DATA:  if (word_ready && last_word) state_next = AFTER_DATA;
`ifdef IMEM_LOADER_CSUM_EN
      ST_CSUM:  if (xfer) state_next = (in_data == csum_reg) ? ST_FLUSH : ST_ERR;
`endif
      ST_FLUSH: state_next = ST_DONE;
      default:  state_next = state_reg;
    endcase
    in_ready_next = accepting(state_next);
    done          = (state_reg == ST_DONE);
    err           = (state_reg == ST_ERR);
    core_hold     = (state_reg != ST_DONE);
  end

  // Header capture, word write pulse, address advance and ready register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_reg  <= 1'b0;
      count_lo_reg  <= '0;
      count_reg     <= '0;
      words_reg     <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      in_ready_reg <= in_ready_next;
      mem_we_reg   <= word_ready;
      if (xfer && state_reg == ST_LEN0) count_lo_reg <= in_data;
      if (xfer && state_reg == ST_LEN1) count_reg    <= hdr_word;
      if (word_ready) begin
        mem_wdata_reg <= word;
        words_reg     <= words_reg + 1'b1;
      end
      // Address moves on after the pulse; a full image wraps it back to 0.
      if (mem_we_reg) mem_addr_reg <= mem_addr_reg + 1'b1;
    end
  end

`ifdef IMEM_LOADER_CSUM_EN
  // Running XOR of data bytes (header excluded).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          csum_reg <= '0;
    else if (pack_en) csum_reg <= csum_reg ^ in_data;
  end
`endif

  assign in_ready  = in_ready_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule
